// File: rtl/eth_pkg.sv
// Shared constants and helpers for the TX pause stage.
// Holds the 802.3x MAC-control constants, the prescaler terminal counts
// derived from the 512-bit quantum, the TX FSM state type, and the byte
// selector for the fixed 18-byte PAUSE header.
package eth_pkg;

  localparam logic [47:0] ETH_PAUSE_DA        = 48'h0180C2000001;
  localparam logic [15:0] ETH_TYPE_MAC_CTRL   = 16'h8808;
  localparam logic [15:0] ETH_OP_PAUSE        = 16'h0001;
  localparam int          ETH_PAUSE_FRAME_LEN = 60;
  localparam int          ETH_QUANTUM_BITS    = 512;

  // One quantum spans 64 byte times on GMII (8 bits per enable) and
  // 128 enables on MII (4 bits per enable).
  localparam logic [6:0] ETH_PRESC_TC_GMII = 7'(ETH_QUANTUM_BITS / 8 - 1);
  localparam logic [6:0] ETH_PRESC_TC_MII  = 7'(ETH_QUANTUM_BITS / 4 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PAUSE} tx_state_t;

  // hdr = {DA, SA, ethertype, opcode, quanta}, 18 bytes MSB first.
  // Shifting past the header yields zero, which is the padding bytes 18-59.
  function automatic logic [7:0] pause_frame_byte(input logic [143:0] hdr,
                                                  input logic [5:0]   idx);
    logic [143:0] sh;
    sh = hdr << {idx, 3'b000};
    return sh[143:136];
  endfunction

endpackage

// File: rtl/eth_pause_quanta_timer.sv
// Received-PAUSE quanta timer.
// A prescaler counts clk_enable cycles to one quantum (64 enables GMII,
// 128 MII); on each wrap the 16-bit counter decrements, saturating at 0.
// A load sets the counter and restarts the prescaler, and wins over a wrap
// in the same cycle.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   clk_enable      byte-time qualifier
//   mii_select      1 = MII timing
//   load            load strobe
//   load_quanta     value to load (0 = resume)
//   paused          registered (counter != 0)
module eth_pause_quanta_timer
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        mii_select,
  input  logic        load,
  input  logic [15:0] load_quanta,
  output logic        paused
);

  logic [6:0]  presc;
  logic [15:0] count;
  logic [15:0] count_nx;
  logic        wrap;

  // >= keeps the prescaler bounded if mii_select changes mid-quantum.
  assign wrap = clk_enable &&
                (presc >= (mii_select ? ETH_PRESC_TC_MII : ETH_PRESC_TC_GMII));

  always_comb begin
    count_nx = count;
    if (load)                        count_nx = load_quanta;
    else if (wrap && count != 16'd0) count_nx = count - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc  <= '0;
      count  <= '0;
      paused <= 1'b0;
    end else begin
      if (load || wrap)    presc <= '0;
      else if (clk_enable) presc <= presc + 7'd1;
      count  <= count_nx;
      paused <= (count_nx != 16'd0);
    end
  end

endmodule

// File: rtl/eth_mac_pause_tx.sv
// TX flow-control stage in front of the 1G MAC transmit path.
// Passes host frames through with zero latency, holds off new frames while
// the received PAUSE counter is nonzero, and injects 60-byte PAUSE frames
// (no FCS) on request. Frames in flight are never truncated.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   s_axis_*              host frame stream in
//   m_axis_*              stream to MAC TX (tuser 0 during PAUSE frames)
//   tx_pause_req/quanta   request a PAUSE frame with the given quanta
//   tx_src_mac            source MAC placed in PAUSE frames
//   rx_pause_valid/quanta received PAUSE, loads the quanta timer
//   clk_enable, mii_select MAC byte timing
//   paused                quanta counter nonzero
//   pause_sent            pulse on accepted tlast of a PAUSE frame
module eth_mac_pause_tx
  import eth_pkg::*;
#(
  parameter int          DATA_WIDTH      = 8,
  parameter int          USER_WIDTH      = 1,
  parameter int          ENABLE_RX_PAUSE = 1,
  parameter int          ENABLE_TX_PAUSE = 1,
  parameter logic [47:0] PAUSE_DA        = ETH_PAUSE_DA,
  parameter logic [15:0] PAUSE_ETHERTYPE = ETH_TYPE_MAC_CTRL,
  parameter logic [15:0] PAUSE_OPCODE    = ETH_OP_PAUSE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  tx_pause_req,
  input  logic [15:0]           tx_pause_quanta,
  input  logic [47:0]           tx_src_mac,
  input  logic                  rx_pause_valid,
  input  logic [15:0]           rx_pause_quanta,
  input  logic                  clk_enable,
  input  logic                  mii_select,
  output logic                  paused,
  output logic                  pause_sent
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_mac_pause_tx: DATA_WIDTH must be 8");
  end

  localparam logic [5:0] PAUSE_LAST = 6'(ETH_PAUSE_FRAME_LEN - 1);

  tx_state_t    state, state_nx;
  logic         pending;
  logic [15:0]  pend_quanta;
  logic [15:0]  tx_quanta;   // frozen for the frame in flight
  logic [5:0]   idx;
  logic [143:0] hdr;
  logic         go_pause;
  logic         tx_req;
  logic         rx_load;

  assign tx_req  = (ENABLE_TX_PAUSE != 0) && tx_pause_req;
  assign rx_load = (ENABLE_RX_PAUSE != 0) && rx_pause_valid;
  assign hdr     = {PAUSE_DA, tx_src_mac, PAUSE_ETHERTYPE, PAUSE_OPCODE, tx_quanta};

  eth_pause_quanta_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .clk_enable  (clk_enable),
    .mii_select  (mii_select),
    .load        (rx_load),
    .load_quanta (rx_pause_quanta),
    .paused      (paused)
  );

  always_comb begin
    state_nx      = state;
    go_pause      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    pause_sent    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A pending PAUSE frame beats a waiting host frame.
        if (pending) begin
          state_nx = ST_PAUSE;
          go_pause = 1'b1;
        end else if (s_axis_tvalid && !paused) begin
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nx = ST_IDLE;
      end
      ST_PAUSE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pause_frame_byte(hdr, idx);
        m_axis_tlast  = (idx == PAUSE_LAST);
        if (m_axis_tready && idx == PAUSE_LAST) begin
          pause_sent = 1'b1;
          state_nx   = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      pend_quanta <= '0;
      tx_quanta   <= '0;
      idx         <= '0;
    end else begin
      state <= state_nx;
      if (go_pause) begin
        tx_quanta <= pend_quanta;
        idx       <= '0;
      end else if (state == ST_PAUSE && m_axis_tready && idx != PAUSE_LAST) begin
        idx <= idx + 6'd1;
      end
      // A request in the launch cycle re-arms pending for one more frame.
      if (tx_req) begin
        pending     <= 1'b1;
        pend_quanta <= tx_pause_quanta;
      end else if (go_pause) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_pause_tx.sv
// Bench for eth_mac_pause_tx: directed scenarios, an expected-beat queue
// for the output stream, and a bit-time model of the received pause.
module tb_eth_mac_pause_tx;

  localparam logic [47:0] DA  = 48'h0180C2000001;
  localparam logic [47:0] SRC = 48'h021122334455;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        tx_pause_req;
  logic [15:0] tx_pause_quanta;
  logic [47:0] tx_src_mac;
  logic        rx_pause_valid;
  logic [15:0] rx_pause_quanta;
  logic        clk_enable;
  logic        mii_select;
  logic        paused;
  logic        pause_sent;

  eth_mac_pause_tx dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .tx_pause_req(tx_pause_req), .tx_pause_quanta(tx_pause_quanta),
    .tx_src_mac(tx_src_mac),
    .rx_pause_valid(rx_pause_valid), .rx_pause_quanta(rx_pause_quanta),
    .clk_enable(clk_enable), .mii_select(mii_select),
    .paused(paused), .pause_sent(pause_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       is_pause;
    logic [5:0] idx;
  } beat_t;

  beat_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         ticks  = 0;   // enables left until the received pause expires
  int         ps_cnt = 0;
  int         bubbles = 0;
  logic [7:0] cap[0:59];
  bit         bp_en  = 0;
  bit         ce_tog = 0;
  int         n, pc, fall, start, vcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // PAUSE frame as the MAC must see it: DA, SA, 8808, 0001, quanta, zero pad.
  task automatic push_pause(input logic [15:0] q);
    logic [143:0] h;
    beat_t e;
    h = {DA, SRC, 16'h8808, 16'h0001, q};
    for (int i = 0; i < 60; i++) begin
      e.data     = (i < 18) ? h[143 - 8*i -: 8] : 8'h00;
      e.last     = (i == 59);
      e.user     = 1'b0;
      e.is_pause = 1'b1;
      e.idx      = 6'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_host(input int len, input logic [7:0] base, input logic ubit,
                           input int req_at, input logic [15:0] req_q);
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = base + 8'(i); e.last = (i == len-1); e.user = ubit && (i == len-1);
      e.is_pause = 1'b0; e.idx = '0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      int   w;
      logic acc;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 8'(i);
      s_axis_tlast  = (i == len-1);
      s_axis_tuser  = ubit && (i == len-1);
      if (i == req_at) begin
        tx_pause_req = 1'b1; tx_pause_quanta = req_q; push_pause(req_q);
      end
      w = 0; acc = 1'b0;
      while (!acc && w < 2000) begin
        @(negedge clk);
        acc = s_axis_tready;
        if (!acc) bubbles++;
        @(posedge clk); #1;
        tx_pause_req = 1'b0;
        w++;
      end
      if (!acc) begin
        errors++; checks++;
        $display("FAIL host_accept_timeout: byte %0d not accepted, required within 2000 cycles", i);
        break;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < budget) begin step(); w++; end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic count_paused(output int cnt);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (paused) cnt++; else break;
    end
  endtask

  // Background MAC-side drivers, offset from the main thread's drive point.
  initial begin
    m_axis_tready = 1'b1;
    clk_enable    = 1'b1;
    forever begin
      @(posedge clk); #2;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      clk_enable    = ce_tog ? ~clk_enable : 1'b1;
    end
  end

  // Compare process: output stream against the queue, pause_sent against the
  // frame position, paused against the remaining bit-time budget.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        ticks = 0;
      end else begin
        chk("paused", paused, ticks != 0);
        if (pause_sent) ps_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("m_tdata", m_axis_tdata, e.data);
            chk("m_tlast", m_axis_tlast, e.last);
            chk("m_tuser", m_axis_tuser, e.user);
            chk("pause_sent", pause_sent, e.is_pause && e.last);
            if (e.is_pause) cap[e.idx] = m_axis_tdata;
          end
        end else begin
          chk("pause_sent_idle", pause_sent, 0);
        end
        if (rx_pause_valid) ticks = rx_pause_quanta * (mii_select ? 128 : 64);
        else if (clk_enable && ticks > 0) ticks--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  int         lit_idx[14] = '{0, 1, 2, 5, 6, 11, 12, 13, 14, 15, 16, 17, 18, 59};
  logic [7:0] lit_val[14] = '{8'h01, 8'h80, 8'hC2, 8'h01, 8'h02, 8'h55, 8'h88,
                              8'h08, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00};

  initial begin
    rst = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    tx_pause_req = 1'b0; tx_pause_quanta = '0; tx_src_mac = SRC;
    rx_pause_valid = 1'b0; rx_pause_quanta = '0; mii_select = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast",  m_axis_tlast, 0);
    chk("rst_m_tuser",  m_axis_tuser, 0);
    chk("rst_m_tdata",  m_axis_tdata, 0);
    chk("rst_paused",   paused, 0);
    chk("rst_pause_sent", pause_sent, 0);
    step(); rst = 1'b1; step();

    // Three back-to-back host frames: one IDLE bubble each
    bubbles = 0;
    send_host(64, 8'h00, 1'b0, -1, '0);
    send_host(64, 8'h55, 1'b1, -1, '0);
    send_host(64, 8'hA0, 1'b0, -1, '0);
    wait_drain("host_drain", 20);
    chk("idle_bubbles", bubbles, 3);
    repeat (4) step();

    // Received pause, quanta=2, GMII: 128 cycles, frame starts right after
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd2;
    step();
    rx_pause_valid = 1'b0;
    pc = 0; fall = -1; start = -1;
    fork
      send_host(64, 8'h40, 1'b0, -1, '0);
      for (int i = 1; i < 400; i++) begin
        @(negedge clk);
        if (paused) pc++; else if (fall < 0) fall = i;
        if (m_axis_tvalid && start < 0) start = i;
      end
    join
    chk("pause2_cycles", pc, 128);
    chk("pause2_fall", fall, 129);
    chk("pause2_start", start, 130);
    wait_drain("pause2_drain", 20);

    // PAUSE request at host byte 10, quanta FFFF
    ps_cnt = 0;
    send_host(64, 8'h80, 1'b1, 10, 16'hFFFF);
    wait_drain("req_drain", 300);
    chk("req_pause_sent_cnt", ps_cnt, 1);
    for (int i = 0; i < 14; i++) chk($sformatf("frame_byte%0d", lit_idx[i]), cap[lit_idx[i]], lit_val[i]);
    repeat (4) step();

    // PAUSE frames under 50% backpressure, second request queued mid-frame
    bp_en = 1;
    tx_pause_req = 1'b1; tx_pause_quanta = 16'h1234; push_pause(16'h1234);
    step();
    tx_pause_req = 1'b0;
    repeat (30) step();
    tx_pause_req = 1'b1; tx_pause_quanta = 16'h0102; push_pause(16'h0102);
    step();
    tx_pause_req = 1'b0;
    wait_drain("bp_drain", 1500);
    bp_en = 0;
    chk("bp_pause_sent_cnt", ps_cnt, 3);
    chk("bp_quanta_hi", cap[16], 8'h01);
    chk("bp_quanta_lo", cap[17], 8'h02);
    repeat (4) step();

    // MII with clk_enable toggling, quanta=1 -> 256 cycles
    mii_select = 1'b1; ce_tog = 1;
    step();
    while (clk_enable != 1'b0) step();
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd1;
    step();
    rx_pause_valid = 1'b0;
    count_paused(n);
    chk("mii_cycles", n, 256);
    // resume with quanta 0 after 100 cycles
    step();
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd1;
    step();
    rx_pause_valid = 1'b0;
    repeat (99) step();
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd0;
    @(negedge clk);
    chk("resume_before", paused, 1);
    step();
    rx_pause_valid = 1'b0;
    @(negedge clk);
    chk("resume_after", paused, 0);
    mii_select = 1'b0; ce_tog = 0;
    repeat (4) step();

    // Load at the terminal count: load wins, 5 full quanta follow
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd1;
    step();
    rx_pause_valid = 1'b0;
    repeat (63) step();
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd5;
    step();
    rx_pause_valid = 1'b0;
    count_paused(n);
    chk("load_wrap_cycles", n, 320);
    repeat (4) step();

    // Reset in the middle of a PAUSE frame with another request pending
    tx_pause_req = 1'b1; tx_pause_quanta = 16'h00AA; push_pause(16'h00AA);
    step();
    tx_pause_req = 1'b0;
    for (int w = 0; w < 200 && exp_q.size() > 40; w++) step();
    tx_pause_req = 1'b1;
    step();
    tx_pause_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tvalid", m_axis_tvalid, 0);
    chk("rst_mid_tlast", m_axis_tlast, 0);
    vcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) vcnt++;
    end
    chk("rst_pending_cleared", vcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_mac_pause_tx.md
Name: eth_mac_pause_tx

Overview:
- Parametrised TX-side flow-control stage placed in front of the 1G MAC transmit path (AXI-stream in, AXI-stream out to MAC TX).
- Honours received 802.3x PAUSE quanta by inhibiting new data frames.
- Injects locally requested PAUSE frames: 60 bytes, no FCS; the MAC appends the FCS.
- Supports GMII and MII byte timing through clk_enable and mii_select.

Parameters:
- DATA_WIDTH, 8: stream width; only 8 is legal; elaboration error otherwise.
- USER_WIDTH, 1: tuser width; bit 0 is the bad-frame flag.
- ENABLE_RX_PAUSE, 1: 0 ties the quanta counter to 0; rx_pause_* are ignored.
- ENABLE_TX_PAUSE, 1: 0 ignores tx_pause_req; the PAUSE state is unreachable.
- PAUSE_DA, 48'h0180C2000001: destination MAC of generated frames.
- PAUSE_ETHERTYPE, 16'h8808: MAC-control ethertype.
- PAUSE_OPCODE, 16'h0001: PAUSE opcode.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  frame data from host
- s_axis_tvalid  in  1  host data valid
- s_axis_tready  out  1  host data accepted
- s_axis_tlast  in  1  last byte of host frame
- s_axis_tuser  in  USER_WIDTH  passed through to MAC
- m_axis_tdata  out  DATA_WIDTH  data to MAC TX
- m_axis_tvalid  out  1  data valid to MAC TX
- m_axis_tready  in  1  MAC TX accepts byte
- m_axis_tlast  out  1  last byte to MAC TX
- m_axis_tuser  out  USER_WIDTH  passed through; 0 during PAUSE frames
- tx_pause_req  in  1  single-cycle request to send a PAUSE frame
- tx_pause_quanta  in  16  quanta value for the requested frame
- tx_src_mac  in  48  source MAC inserted in PAUSE frames
- rx_pause_valid  in  1  single-cycle strobe: a valid PAUSE was received
- rx_pause_quanta  in  16  received quanta value
- clk_enable  in  1  byte-time qualifier; same meaning as in the MAC
- mii_select  in  1  1 = MII timing (2 enables per byte)
- paused  out  1  quanta counter nonzero
- pause_sent  out  1  one-cycle pulse on accepted tlast of a PAUSE frame

Behaviour:
Reset (rst=0 on a clk edge):
- All outputs 0.
- state=IDLE; pause counter=0; prescaler=0; pending=0.
- Reset mid-frame drops m_axis_tvalid on the next cycle with no tlast. This is accepted; the MAC flags underflow.

State machine (IDLE, DATA, PAUSE):
- IDLE: s_axis_tready=0, m_axis_tvalid=0. Priority on each cycle:
  - pending=1 goes to PAUSE. pend_quanta is copied to the frozen tx_quanta register, and the byte index is cleared.
  - Else, s_axis_tvalid=1 and pause counter==0 goes to DATA.
  - Else, stay in IDLE.
- DATA: combinational pass-through, zero latency.
  - m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready; data, last and user are forwarded.
  - An accepted beat with tlast returns to IDLE.
  - A pause or request arriving mid-frame never truncates the frame.
- PAUSE: emits 60 bytes, index 0..59.
  - Bytes 0-5: PAUSE_DA, MSB first.
  - Bytes 6-11: tx_src_mac, MSB first.
  - Bytes 12-13: ethertype.
  - Bytes 14-15: opcode.
  - Bytes 16-17: tx_quanta, MSB first.
  - Bytes 18-59: 0x00.
  - m_axis_tvalid=1 throughout. The index advances only when m_axis_tready=1. tlast is asserted at index 59.
  - On acceptance of byte 59: pause_sent pulses, go to IDLE.
  - s_axis_tready=0 in this state.
  - PAUSE frames are sent even while paused=1.

Request latch:
- tx_pause_req=1 sets pending=1 and writes pend_quanta=tx_pause_quanta. If several requests arrive, the latest one wins.
- pending clears on the IDLE-to-PAUSE transition. A request in that same cycle re-sets pending.
- A request during PAUSE does not alter the frame in flight; it queues one further frame.

Pause counter (16-bit) and prescaler:
- One quantum = 512 bit times. The prescaler counts clk_enable=1 cycles up to a terminal count of 63 (GMII) or 127 (MII), then wraps to 0. On wrap, the counter decrements if nonzero and saturates at 0.
- rx_pause_valid loads the counter with rx_pause_quanta (0 means resume) and clears the prescaler.
- A load in the same cycle as a wrap: the load wins.
- paused = (counter != 0), registered.

Decomposition:
- eth_pkg holds the shared constants: ETH_PAUSE_DA, ETH_TYPE_MAC_CTRL, ETH_OP_PAUSE, ETH_PAUSE_FRAME_LEN=60, ETH_QUANTUM_BITS=512.
- One natural sub-module: eth_pause_quanta_timer (prescaler plus counter, load and saturation). The FSM and byte mux stay in the top module.

Test Plan:
- Reset, then three host frames of 64 bytes with m_axis_tready=1 -> identical bytes out; s_axis_tready low only in the single IDLE bubble cycle per frame.
- rx_pause_valid with quanta=2 in GMII mode with clk_enable=1 -> paused for exactly 128 cycles, with no host frame started meanwhile; the frame starts on the cycle after paused falls.
- tx_pause_req with quanta=0xFFFF at host byte 10 -> host frame completes; next frame out is 01 80 C2 00 00 01, src MAC, 88 08 00 01 FF FF, 42 zero bytes, tlast on byte 60; pause_sent pulses once.
- Random m_axis_tready backpressure (50%) during a PAUSE frame -> the 60-byte sequence is unchanged; no byte is skipped or duplicated.
- mii_select=1, clk_enable toggling every cycle, quanta=1 -> counter clears after 256 clk cycles; rx_pause_valid with quanta=0 at cycle 100 -> paused falls on the next cycle.
- Load and wrap in the same cycle (quanta=5 at the terminal count) -> counter reads 5, prescaler 0; rst=0 mid-PAUSE -> tvalid=0 next cycle, and pending stays 0 after release.
